sfp_drain: RTL
==============

# sfp_drain

Output drain stage that sits directly downstream of a core's `sfp_out` bus. It accepts full SFP result vectors (`col` lanes of `psum_bw` bits) through a valid/ready handshake and buffers them in a small vector FIFO. It serializes each vector into narrower output words for the off-chip/output-SRAM interface and marks the last word of each vector. Each core gets one instance, clocked by that core's clock.

## Interface

- `col`, 8, number of psum lanes per vector
- `psum_bw`, 16, bits per psum lane
- `lanes_per_word`, 2, psum lanes packed per output word; must divide `col`
- `depth`, 4, vector FIFO entries; power of two, ≥2
- `clk`  in  1  the block's only clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_data` holds a vector
- `in_data`  in  `col*psum_bw`  SFP vector; lane i at bits `[psum_bw*(i+1)-1 : psum_bw*i]`
- `in_ready`  out  1  block accepts a vector this cycle
- `out_valid`  out  1  `out_data` holds a word
- `out_data`  out  `lanes_per_word*psum_bw`  serialized word
- `out_last`  out  1  current word is the final word of its vector
- `out_ready`  in  1  downstream accepts the word this cycle
- `vec_cnt`  out  16  count of fully drained vectors; wraps modulo 2^16

## Operation

- Push: on a rising edge where `in_valid & in_ready`, `in_data` is written at the write pointer.
  - `in_ready = !fifo_full`, computed combinationally from registered state only.
  - A pop in the same cycle does not free space for that cycle's push.
- FIFO pointers carry `log2(depth)+1` bits; the extra MSB distinguishes full from empty.
  - Full when the indices are equal and the MSBs differ; empty when all bits are equal.
  - Pointers wrap naturally.
- Serializer holds one vector in a shift register plus a word index `widx` of `log2(col/lanes_per_word)` bits.
- Serializer states:
  - IDLE: `out_valid=0`. If the FIFO is non-empty, load the head, pop it, set `widx=0`, go to SEND.
  - SEND: `out_valid=1`; `out_data` is lanes `[widx*lanes_per_word .. +lanes_per_word-1]`, lowest lane in the LSBs.
  - SEND, on `out_ready` and not the last word: increment `widx`.
  - SEND, on `out_ready` and the last word: increment `vec_cnt`. If the FIFO is non-empty, load the next head at the same edge and stay in SEND; otherwise go to IDLE.
- `out_last = (state==SEND) & (widx == col/lanes_per_word-1)`.
- `out_data` and `out_last` stay stable while `out_valid & !out_ready`.
- Total capacity is `depth+1` vectors (FIFO plus serializer register).
- No arithmetic on the data; lanes pass through bit-exact.

## Timing

- While `reset` is low:
  - all pointers, `widx` and `vec_cnt` are 0; the FIFO is empty and the state is IDLE;
  - outputs: `out_valid=0`, `out_last=0`, `out_data=0`, `in_ready=1`.
- Reset asserted mid-vector: the partial vector and all buffered vectors are discarded. Nothing resumes after release.
- Latency: a vector pushed at edge E0 into an empty block produces its first word with `out_valid=1` in the cycle after edge E1.
- Throughput is one word per cycle while `out_ready=1`, with no bubble between consecutive vectors when the FIFO is non-empty.
- `vec_cnt` updates at the same edge that completes the last-word handshake.
- `out_ready` asserted while `out_valid=0` has no effect.

## Structure

- Shared package `sfp_drain_pkg` holds:
  - default constants `COL`, `PSUM_BW`, `LANES_PER_WORD`, `DEPTH`;
  - derived `WORDS_PER_VEC` and `PTR_W`;
  - the state enum `{IDLE, SEND}`.
- Sub-module `vec_fifo`: parameterized synchronous FIFO, width `col*psum_bw`, `depth` entries, with ports `push`, `pop`, `wdata`, `rdata`, `full`, `empty`. Same clock and reset as the parent.
- Top level contains the serializer FSM and `vec_cnt`.

## Test plan

- Single vector with lanes 0..7 = `16'h0001..16'h0008`, `out_ready=1`:
  - words `32'h0002_0001`, `32'h0004_0003`, `32'h0006_0005`, `32'h0008_0007` on consecutive cycles;
  - `out_last` only on the 4th word;
  - `vec_cnt=1`.
- Fill with `out_ready=0`, pushing every cycle: exactly 5 vectors accepted, then `in_ready=0`. Raising `out_ready` drains 20 words in push order; `in_ready` returns to 1 after the first vector is loaded.
- Three back-to-back vectors with `out_ready=1`: 12 consecutive valid words with no bubble, and `vec_cnt=3`.
- Backpressure: toggle `out_ready` 1,0,0,1,... mid-vector. `out_data` is held while stalled, no word is duplicated or lost, and `out_last` is aligned to the 4th word.
- Pull `reset` low after 2 words of a vector with 2 more vectors queued:
  - outputs go to their reset values immediately;
  - after release, `out_valid` stays 0 and `vec_cnt=0`;
  - a new vector then drains correctly.
- Run 65 537 vectors and check that `vec_cnt` wraps to 1.

Source files
------------

// File: rtl/sfp_drain_pkg.sv
// Shared constants and types for the SFP output drain: default geometry and serializer state.
package sfp_drain_pkg;
    localparam int COL            = 8;
    localparam int PSUM_BW        = 16;
    localparam int LANES_PER_WORD = 2;
    localparam int DEPTH          = 4;

    localparam int WORDS_PER_VEC  = COL / LANES_PER_WORD;
    localparam int PTR_W          = $clog2(DEPTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/vec_fifo.sv
// Synchronous vector FIFO; pointers carry one extra MSB so full and empty are distinguishable.
module vec_fifo
    import sfp_drain_pkg::*;
#(
    parameter int width = COL * PSUM_BW,
    parameter int depth = DEPTH,
    parameter int ptr_w = PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int IDX_W = ptr_w - 1;

    logic [width-1:0] r_mem [depth];
    logic [ptr_w-1:0] r_wr_ptr;
    logic [ptr_w-1:0] r_rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !full)
                r_wr_ptr <= r_wr_ptr + ptr_w'(1);
            if (pop && !empty)
                r_rd_ptr <= r_rd_ptr + ptr_w'(1);
        end
    end

    // Storage is data only; it carries no reset.
    always_ff @(posedge clk) begin
        if (push && !full)
            r_mem[r_wr_ptr[IDX_W-1:0]] <= wdata;
    end

    assign full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                   (r_wr_ptr[ptr_w-1] != r_rd_ptr[ptr_w-1]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign rdata = r_mem[r_rd_ptr[IDX_W-1:0]];
endmodule

// File: rtl/sfp_drain.sv
// SFP output drain: buffers result vectors and serializes them into narrow words with a last-word flag.
module sfp_drain
    import sfp_drain_pkg::*;
#(
    parameter int col            = COL,
    parameter int psum_bw        = PSUM_BW,
    parameter int lanes_per_word = LANES_PER_WORD,
    parameter int depth          = DEPTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [col*psum_bw-1:0]             in_data,
    output logic                               in_ready,
    output logic                               out_valid,
    output logic [lanes_per_word*psum_bw-1:0]  out_data,
    output logic                               out_last,
    input  logic                               out_ready,
    output logic [15:0]                        vec_cnt
);
    localparam int VEC_W  = col * psum_bw;
    localparam int WORD_W = lanes_per_word * psum_bw;
    localparam int WPV    = col / lanes_per_word;
    localparam int WIDX_W = (WPV > 1) ? $clog2(WPV) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [VEC_W-1:0]   r_vec;
    logic [VEC_W-1:0]   w_head;
    logic [WIDX_W-1:0]  r_widx;
    logic [15:0]        r_vec_cnt;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_load;
    logic               w_fire;
    logic               w_last;

    // Readiness depends on registered occupancy only, so a same-cycle pop never admits a push.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign vec_cnt  = r_vec_cnt;

    vec_fifo #(
        .width (VEC_W),
        .depth (depth),
        .ptr_w ($clog2(depth) + 1)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_load),
        .wdata (in_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (!w_empty) w_next_state = SEND;
            SEND: if (w_fire && w_last && w_empty) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The next head is loaded on the last-word handshake so vectors stream without a bubble.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        w_last    = 1'b0;
        w_fire    = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            IDLE: w_load = !w_empty;
            SEND: begin
                out_valid = 1'b1;
                w_last    = (r_widx == WIDX_W'(WPV - 1));
                out_last  = w_last;
                out_data  = r_vec[WORD_W-1:0];
                w_fire    = out_ready;
                w_load    = out_ready && w_last && !w_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_load)
            r_vec <= w_head;
        else if (w_fire)
            r_vec <= r_vec >> WORD_W;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_widx    <= '0;
            r_vec_cnt <= '0;
        end else begin
            if (w_load)
                r_widx <= '0;
            else if (w_fire)
                r_widx <= r_widx + WIDX_W'(1);
            if (w_fire && w_last)
                r_vec_cnt <= r_vec_cnt + 16'd1;
        end
    end
endmodule
